// File: rtl/bram_multi_read.sv
// Block RAM with one write port and RAM_PORTS registered read ports.
// Ports: i_clk, i_rst, i_r_addrs (packed), i_w_addrs, i_wr_en, i_data, o_data (packed).
module bram_multi_read #(
  parameter int ADDR_WIDTH = 6,
  parameter int RAM_WIDTH  = 8,
  parameter int RAM_PORTS  = 3
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [ADDR_WIDTH*RAM_PORTS-1:0] i_r_addrs,
  input  logic [ADDR_WIDTH-1:0]           i_w_addrs,
  input  logic                            i_wr_en,
  input  logic [RAM_WIDTH-1:0]            i_data,
  output logic [RAM_WIDTH*RAM_PORTS-1:0]  o_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef logic [RAM_WIDTH-1:0]  word_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;

  word_t mem_q [DEPTH] = '{default: '0};

  word_t [RAM_PORTS-1:0] rd_q;
  word_t [RAM_PORTS-1:0] rd_d;

  logic  we_d;
  addr_t wa_d;
  word_t wd_d;

  always_comb begin
    we_d = i_wr_en & ~i_rst;
    wa_d = i_w_addrs;
    wd_d = i_data;
  end

  // Array read happens before the write lands, so a same-cycle
  // collision returns the old word.
  for (genvar k = 0; k < RAM_PORTS; k++) begin : g_rd
    addr_t ra;
    always_comb begin
      ra      = i_r_addrs[k*ADDR_WIDTH +: ADDR_WIDTH];
      rd_d[k] = mem_q[ra];
    end
  end

  always_ff @(posedge i_clk) begin
    if (we_d) begin
      mem_q[wa_d] <= wd_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_d;
    end
  end

  assign o_data = rd_q;

endmodule

// File: tb/tb_bram_multi_read.sv
// Scoreboard bench for bram_multi_read.
// Expected words are queued as stimulus is driven and checked next cycle.
module tb_bram_multi_read;

  localparam int AW = 6;
  localparam int DW = 8;
  localparam int NP = 3;

  logic               clk;
  logic               rst;
  logic [AW*NP-1:0]   r_addrs;
  logic [AW-1:0]      w_addr;
  logic               wr_en;
  logic [DW-1:0]      wdata;
  logic [DW*NP-1:0]   rdata;

  int total = 0;
  int bad   = 0;

  logic [DW*NP-1:0] sb_q [$];
  logic [DW*NP-1:0] exp;
  logic [DW-1:0]    mdl [64];

  bram_multi_read #(
    .ADDR_WIDTH(AW),
    .RAM_WIDTH (DW),
    .RAM_PORTS (NP)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_r_addrs(r_addrs),
    .i_w_addrs(w_addr),
    .i_wr_en  (wr_en),
    .i_data   (wdata),
    .o_data   (rdata)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, total=%0d", total);
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1; wr_en = 0; w_addr = 0; wdata = 0;
    r_addrs = {6'd2, 6'd1, 6'd0};
    for (int i = 0; i < 2; i++) begin
      sb_q.push_back('0);
      tick;
      exp = sb_q.pop_front();
      total++;
      if (rdata !== exp) begin
        bad++;
        $display("FAIL reset_out: got %h want %h", rdata, exp);
      end
    end
    rst = 0;
    r_addrs = {6'd63, 6'd40, 6'd10};
    sb_q.push_back('0);
    tick;
    exp = sb_q.pop_front();
    total++;
    if (rdata !== exp) begin
      bad++;
      $display("FAIL init_zero: got %h want %h", rdata, exp);
    end
  endtask

  task automatic test_write_burst;
    logic [AW*NP-1:0] a [3];
    logic [DW*NP-1:0] e [3];
    a[0] = {6'd2, 6'd1, 6'd0}; e[0] = {8'd3, 8'd2, 8'd1};
    a[1] = {6'd5, 6'd4, 6'd3}; e[1] = {8'd6, 8'd5, 8'd4};
    a[2] = {6'd8, 6'd7, 6'd6}; e[2] = {8'd9, 8'd8, 8'd7};
    wr_en = 1;
    for (int i = 0; i < 9; i++) begin
      w_addr = AW'(i);
      wdata  = DW'(i + 1);
      mdl[i] = DW'(i + 1);
      tick;
    end
    wr_en = 0;
    for (int i = 0; i < 3; i++) begin
      r_addrs = a[i];
      sb_q.push_back(e[i]);
      tick;
      exp = sb_q.pop_front();
      total++;
      if (rdata !== exp) begin
        bad++;
        $display("FAIL burst_read%0d: got %h want %h", i, rdata, exp);
      end
    end
  endtask

  task automatic test_same_addr;
    r_addrs = {6'd4, 6'd4, 6'd4};
    sb_q.push_back({8'd5, 8'd5, 8'd5});
    tick;
    exp = sb_q.pop_front();
    total++;
    if (rdata !== exp) begin
      bad++;
      $display("FAIL same_addr: got %h want %h", rdata, exp);
    end
    r_addrs = {6'd63, 6'd40, 6'd10};
    sb_q.push_back('0);
    tick;
    exp = sb_q.pop_front();
    total++;
    if (rdata !== exp) begin
      bad++;
      $display("FAIL unwritten: got %h want %h", rdata, exp);
    end
  endtask

  task automatic test_collision;
    r_addrs = {6'd3, 6'd3, 6'd3};
    wr_en = 1; w_addr = 6'd3; wdata = 8'hAA;
    sb_q.push_back({8'd4, 8'd4, 8'd4});
    tick;
    mdl[3] = 8'hAA;
    wr_en = 0;
    exp = sb_q.pop_front();
    total++;
    if (rdata !== exp) begin
      bad++;
      $display("FAIL rdw_old: got %h want %h", rdata, exp);
    end
    sb_q.push_back({8'hAA, 8'hAA, 8'hAA});
    tick;
    exp = sb_q.pop_front();
    total++;
    if (rdata !== exp) begin
      bad++;
      $display("FAIL rdw_new: got %h want %h", rdata, exp);
    end
  endtask

  task automatic test_reset_read;
    r_addrs = {6'd2, 6'd1, 6'd0};
    rst = 1;
    sb_q.push_back('0);
    tick;
    rst = 0;
    exp = sb_q.pop_front();
    total++;
    if (rdata !== exp) begin
      bad++;
      $display("FAIL rst_read: got %h want %h", rdata, exp);
    end
    sb_q.push_back({8'd3, 8'd2, 8'd1});
    tick;
    exp = sb_q.pop_front();
    total++;
    if (rdata !== exp) begin
      bad++;
      $display("FAIL rst_retain: got %h want %h", rdata, exp);
    end
  endtask

  task automatic test_write_in_reset;
    rst = 1; wr_en = 1; w_addr = 6'd20; wdata = 8'h55;
    tick;
    rst = 0; wr_en = 0;
    r_addrs = {6'd20, 6'd20, 6'd20};
    sb_q.push_back('0);
    tick;
    exp = sb_q.pop_front();
    total++;
    if (rdata !== exp) begin
      bad++;
      $display("FAIL wr_in_rst: got %h want %h", rdata, exp);
    end
  endtask

  task automatic test_reset_mid_burst;
    wr_en = 1;
    w_addr = 6'd30; wdata = 8'h11; mdl[30] = 8'h11;
    tick;
    rst = 1;
    w_addr = 6'd31; wdata = 8'h22;
    tick;
    rst = 0;
    w_addr = 6'd32; wdata = 8'h33; mdl[32] = 8'h33;
    tick;
    wr_en = 0;
    r_addrs = {6'd32, 6'd31, 6'd30};
    sb_q.push_back({8'h33, 8'h00, 8'h11});
    tick;
    exp = sb_q.pop_front();
    total++;
    if (rdata !== exp) begin
      bad++;
      $display("FAIL mid_burst_rst: got %h want %h", rdata, exp);
    end
  endtask

  task automatic test_back_to_back;
    logic [AW*NP-1:0] a [3];
    logic [DW*NP-1:0] e [3];
    a[0] = {6'd0, 6'd1, 6'd2}; e[0] = {8'd1, 8'd2, 8'd3};
    a[1] = {6'd3, 6'd4, 6'd5}; e[1] = {8'hAA, 8'd5, 8'd6};
    a[2] = {6'd8, 6'd7, 6'd6}; e[2] = {8'd9, 8'd8, 8'd7};
    r_addrs = a[0];
    sb_q.push_back(e[0]);
    for (int i = 0; i < 3; i++) begin
      tick;
      if (i < 2) begin
        r_addrs = a[i+1];
        sb_q.push_back(e[i+1]);
      end
      exp = sb_q.pop_front();
      total++;
      if (rdata !== exp) begin
        bad++;
        $display("FAIL b2b%0d: got %h want %h", i, rdata, exp);
      end
    end
  endtask

  task automatic test_random;
    logic [AW-1:0] ra [NP];
    for (int n = 0; n < 16; n++) begin
      for (int k = 0; k < NP; k++) begin
        ra[k] = AW'($urandom_range(0, 63));
        r_addrs[k*AW +: AW] = ra[k];
        exp[k*DW +: DW] = mdl[ra[k]];
      end
      sb_q.push_back(exp);
      tick;
      exp = sb_q.pop_front();
      total++;
      if (rdata !== exp) begin
        bad++;
        $display("FAIL rand%0d: addrs %h got %h want %h",
                 n, r_addrs, rdata, exp);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mdl[i] = '0;
    test_reset;
    test_write_burst;
    test_same_addr;
    test_collision;
    test_reset_read;
    test_write_in_reset;
    test_reset_mid_burst;
    test_back_to_back;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bram_multi_read.md
Name: bram_multi_read

Overview:
- Single-clock block RAM with one write port and RAM_PORTS independent synchronous read ports.
- The convolution datapath uses it to store incoming pixel/weight bytes and fetch several, e.g. one 3-element row of a 3x3 window, in a single cycle.
- The read ports are packed side by side into one address bus and one data bus.

Parameters:
- ADDR_WIDTH, default 6: address width per port; depth = 2**ADDR_WIDTH words (64).
- RAM_WIDTH, default 8: word width in bits.
- RAM_PORTS, default 3: number of parallel read ports.

Ports:
- i_clk  input  1: clock; all activity on the rising edge.
- i_rst  input  1: synchronous reset, active-high.
- i_r_addrs  input  ADDR_WIDTH*RAM_PORTS: packed read addresses; port k uses bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- i_w_addrs  input  ADDR_WIDTH: write address.
- i_wr_en  input  1: write enable.
- i_data  input  RAM_WIDTH: write data.
- o_data  output  RAM_WIDTH*RAM_PORTS: packed read data; port k drives bits [k*RAM_WIDTH +: RAM_WIDTH].

Behaviour:
- Storage: array of 2**ADDR_WIDTH words of RAM_WIDTH bits.
- Initial contents are all zero (initialised at elaboration). Reset does not clear the array.
- Write: at a rising edge with i_wr_en=1 and i_rst=0, mem[i_w_addrs] <= i_data. One word per cycle.
- Write while i_rst=1: suppressed.
- Read: at every rising edge with i_rst=0, each port k registers o_data[k] <= mem[i_r_addrs[k]].
  - Latency is exactly 1 cycle from address change to valid data.
  - Reads are unconditional; there is no read enable.
  - o_data holds its value until the next edge.
- Ports are fully independent. Any ports may address the same word and then return identical data.
- Read-during-write to the same address in the same cycle is read-first: that port returns the old contents, and the new value is visible from the next cycle's read.
- Reset:
  - While i_rst=1 at a rising edge, o_data <= 0, all ports.
  - After reset deasserts, the first edge loads normal read data.
  - Reset mid-write-burst: writes in reset cycles are lost; words written earlier are retained.
- Address space: full 2**ADDR_WIDTH range is valid. No out-of-range case, no wrap logic.
- No handshake, no full/empty flags; the caller sequences addresses.
- Implementation: RAM_PORTS read ports via a generate loop over one shared array, or replicated arrays written in parallel. Both are acceptable if the behaviour above holds.

Test Plan:
- Write burst: hold i_wr_en=1 and write 1..9 to addresses 0..8, one per cycle; deassert i_wr_en. Then i_r_addrs={2,1,0} -> one cycle later o_data={8'd3,8'd2,8'd1}; {5,4,3} -> {6,5,4}; {8,7,6} -> {9,8,7}.
- Same-address multi-port: i_r_addrs={4,4,4} after the burst -> o_data={5,5,5}. Unwritten address {63,40,10} -> {0,0,0}.
- Read-first collision: mem[3]=4, write 8'hAA to address 3 while i_r_addrs={3,3,3} -> next cycle {4,4,4}; following cycle {AA,AA,AA}.
- Reset: assert i_rst for one cycle while reading {2,1,0} -> o_data=0 that cycle. After release -> {3,2,1}, proving contents are retained.
- Write during reset: i_rst=1, i_wr_en=1, write 8'h55 to address 20 -> after reset, reading address 20 returns 0.
- Latency check: change i_r_addrs every cycle through {0,1,2},{3,4,5} -> o_data tracks each address exactly one cycle later with no bubbles.
